// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: instruction memory request/response, redirect input and
// the issue port toward decode. The fetch unit is the master side.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              issue_ready;
    logic              issue_valid;
    logic [31:0]       instr;
    logic [5:0]        op;
    logic [5:0]        funct;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output imem_req, imem_addr, issue_valid, instr, op, funct, instr_pc,
        input  imem_ack, imem_rdata, redirect, redirect_pc, issue_ready
    );

    modport slave (
        input  imem_req, imem_addr, issue_valid, instr, op, funct, instr_pc,
        output imem_ack, imem_rdata, redirect, redirect_pc, issue_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetcher: one outstanding memory request, a small
// prefetch FIFO of {pc, word}, and flush/restart on branch redirect.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master fif
);
    localparam int          PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       word;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       count_q, count_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic              discard_q, discard_d;
    logic [ADDR_W-1:0] redirect_pc_al;
    logic              push, pop, valid;
    entry_t            head;
    logic [31:0]       instr_w;

    always_comb begin
        redirect_pc_al = fif.redirect_pc & ~ADDR_W'(3);
        push = req_q && fif.imem_ack && !discard_q && !fif.redirect;
        pop  = valid && fif.issue_ready && !fif.redirect;

        count_d = count_q;
        if (fif.redirect)
            count_d = '0;
        else if (push && !pop)
            count_d = count_q + (PW+1)'(1);
        else if (!push && pop)
            count_d = count_q - (PW+1)'(1);

        fetch_pc_d = fetch_pc_q;
        if (fif.redirect)
            fetch_pc_d = redirect_pc_al;
        else if (push)
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);

        discard_d = discard_q;
        if (fif.redirect)
            discard_d = req_q && !fif.imem_ack;
        else if (req_q && fif.imem_ack)
            discard_d = 1'b0;

        // A pending request is never retracted, even across a redirect; its
        // response is dropped through discard_q instead.
        if (req_q && !fif.imem_ack) begin
            req_d  = 1'b1;
            addr_d = addr_q;
        end else begin
            req_d  = count_d < FULL;
            addr_d = fetch_pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            discard_q  <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            if (fif.redirect) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Storage needs no reset: empty entries are masked on the way out.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {fetch_pc_q, fif.imem_rdata};
    end

    assign head    = mem_q[rd_ptr_q];
    assign valid   = count_q != '0;
    assign instr_w = valid ? head.word : '0;

    assign fif.imem_req    = req_q;
    assign fif.imem_addr   = addr_q;
    assign fif.issue_valid = valid;
    assign fif.instr       = instr_w;
    assign fif.op          = instr_w[31:26];
    assign fif.funct       = instr_w[5:0];
    assign fif.instr_pc    = valid ? head.pc : '0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a 1-cycle-ack memory model fills a scoreboard
// of expected {pc, word}; a monitor pops it on every issue handshake.
module tb_instr_fetch_unit;
    localparam int          ADDR_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_en = 1'b0, ack_r = 1'b0, stale_ack = 1'b0;
    logic        redir_r = 1'b0, ready_r = 1'b0;
    logic [31:0] rdata_r = '0, stale_data = '0, redir_pc_r = '0;
    int          wcnt = 0, drop_req = 0, drops_done = 0;
    int          total = 0, bad = 0;
    exp_t        sb [$];
    logic [31:0] ack_log [$];
    exp_t        mon_e;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(ADDR_W)) fif();

    assign fif.imem_ack    = ack_r | stale_ack;
    assign fif.imem_rdata  = stale_ack ? stale_data : rdata_r;
    assign fif.redirect    = redir_r;
    assign fif.redirect_pc = redir_pc_r;
    assign fif.issue_ready = ready_r;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fif   (fif)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h012A4020;
        return {a[7:2] ^ 6'h2A, 10'h155, a[15:0]};
    endfunction

    // Memory: acks each request one cycle after it is first seen.
    always @(negedge clk) begin
        if (!rst_n || !mem_en || !fif.imem_req) begin
            ack_r <= 1'b0;
            wcnt  <= 0;
        end else if (ack_r) begin
            ack_r <= 1'b0;
            wcnt  <= 1;
        end else if (wcnt >= 1) begin
            ack_r   <= 1'b1;
            rdata_r <= mem_word(fif.imem_addr);
            ack_log.push_back(fif.imem_addr);
            if (drops_done < drop_req) drops_done <= drops_done + 1;
            else sb.push_back({fif.imem_addr, mem_word(fif.imem_addr)});
        end else begin
            wcnt <= wcnt + 1;
        end
    end

    // Issue monitor and request-stability check.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (prev_pend && fif.imem_req) begin
                total++;
                if (fif.imem_addr !== prev_addr) begin
                    bad++;
                    $display("FAIL addr_hold: got %h want %h", fif.imem_addr, prev_addr);
                end
            end
            if (fif.issue_valid && ready_r && !redir_r) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL issue_unexpected: got pc %h word %h want none", fif.instr_pc, fif.instr);
                end else begin
                    mon_e = sb.pop_front();
                    if (fif.instr !== mon_e.word || fif.instr_pc !== mon_e.pc ||
                        fif.op !== mon_e.word[31:26] || fif.funct !== mon_e.word[5:0]) begin
                        bad++;
                        $display("FAIL issue_data: got pc %h word %h op %h funct %h want pc %h word %h",
                                 fif.instr_pc, fif.instr, fif.op, fif.funct, mon_e.pc, mon_e.word);
                    end
                end
            end
            prev_pend <= fif.imem_req && !fif.imem_ack;
            prev_addr <= fif.imem_addr;
        end else begin
            prev_pend <= 1'b0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        mem_en = 1'b0; redir_r = 1'b0; stale_ack = 1'b0; ready_r = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        sb.delete();
        ack_log.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        step();
        step();
        total++;
        if (fif.imem_req !== 1'b0 || fif.imem_addr !== RESET_PC || fif.issue_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got req %b addr %h valid %b want 0 %h 0",
                     fif.imem_req, fif.imem_addr, fif.issue_valid, RESET_PC);
        end
        total++;
        if (fif.instr !== 32'h0 || fif.op !== 6'h0 || fif.funct !== 6'h0 || fif.instr_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_data: got instr %h op %h funct %h pc %h want all 0",
                     fif.instr, fif.op, fif.funct, fif.instr_pc);
        end
    endtask

    task automatic test_stream();
        int n;
        rst_n = 1'b1; ready_r = 1'b1; mem_en = 1'b1;
        n = 0;
        while (!fif.imem_req && n < 20) begin step(); n++; end
        total++;
        if (fif.imem_req !== 1'b1 || fif.imem_addr !== RESET_PC) begin
            bad++;
            $display("FAIL stream_first_req: got req %b addr %h want 1 %h", fif.imem_req, fif.imem_addr, RESET_PC);
        end
        n = 0;
        while (!fif.issue_valid && n < 20) begin step(); n++; end
        total++;
        if (n !== 2) begin
            bad++;
            $display("FAIL stream_latency: got %0d want 2 cycles", n);
        end
        total++;
        if (fif.instr !== 32'h012A4020 || fif.op !== 6'h00 || fif.funct !== 6'h20 || fif.instr_pc !== 32'h0) begin
            bad++;
            $display("FAIL stream_first_word: got %h op %h funct %h pc %h want 012a4020 00 20 0",
                     fif.instr, fif.op, fif.funct, fif.instr_pc);
        end
        repeat (14) step();
        total++;
        if (ack_log.size() < 3) begin
            bad++;
            $display("FAIL stream_addr_seq: got %0d acks want >=3", ack_log.size());
        end else if (ack_log[0] !== 32'h0 || ack_log[1] !== 32'h4 || ack_log[2] !== 32'h8) begin
            bad++;
            $display("FAIL stream_addr_seq: got %h %h %h want 0 4 8", ack_log[0], ack_log[1], ack_log[2]);
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        mem_en = 1'b1;
        repeat (20) step();
        total++;
        if (ack_log.size() !== DEPTH) begin
            bad++;
            $display("FAIL bp_acks: got %0d want %0d", ack_log.size(), DEPTH);
        end
        total++;
        if (fif.imem_req !== 1'b0 || fif.issue_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_full_state: got req %b valid %b want 0 1", fif.imem_req, fif.issue_valid);
        end
        ready_r = 1'b1;
        n = 0;
        while (ack_log.size() < 5 && n < 40) begin step(); n++; end
        total++;
        if (ack_log.size() < 5) begin
            bad++;
            $display("FAIL bp_resume: got %0d acks want 5", ack_log.size());
        end else if (ack_log[4] !== 32'h10) begin
            bad++;
            $display("FAIL bp_resume: got addr %h want 00000010", ack_log[4]);
        end
        mem_en = 1'b0;
        repeat (10) step();
        total++;
        if (sb.size() !== 0 || fif.issue_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain: got %0d pending valid %b want 0 0", sb.size(), fif.issue_valid);
        end
    endtask

    task automatic test_full_pushpop();
        int n;
        do_reset();
        mem_en = 1'b1;
        repeat (15) step();
        for (int i = 0; i < 60; i++) begin
            ready_r = fif.imem_ack ? 1'b1 : ($urandom_range(0, 3) == 0);
            step();
        end
        ready_r = 1'b0;
        repeat (10) step();
        total++;
        if (fif.issue_valid !== 1'b1 || fif.imem_req !== 1'b0 || sb.size() !== DEPTH) begin
            bad++;
            $display("FAIL full_refill: got valid %b req %b pending %0d want 1 0 %0d",
                     fif.issue_valid, fif.imem_req, sb.size(), DEPTH);
        end
        mem_en = 1'b0; ready_r = 1'b1;
        n = 0;
        while (fif.issue_valid && n < 20) begin step(); n++; end
        total++;
        if (n !== DEPTH) begin
            bad++;
            $display("FAIL full_drain_count: got %0d want %0d", n, DEPTH);
        end
        ready_r = 1'b0;
    endtask

    task automatic test_redirect();
        int n;
        do_reset();
        mem_en = 1'b1;
        n = 0;
        while (ack_log.size() < 2 && n < 20) begin step(); n++; end
        mem_en = 1'b0;
        step();
        total++;
        if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h8 || fif.issue_valid !== 1'b1) begin
            bad++;
            $display("FAIL redir_setup: got req %b addr %h valid %b want 1 8 1",
                     fif.imem_req, fif.imem_addr, fif.issue_valid);
        end
        redir_r = 1'b1; redir_pc_r = 32'h103;
        sb.delete();
        drop_req++;
        step();
        redir_r = 1'b0; ready_r = 1'b1;
        total++;
        if (fif.issue_valid !== 1'b0 || fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h8) begin
            bad++;
            $display("FAIL redir_flush: got valid %b req %b addr %h want 0 1 8",
                     fif.issue_valid, fif.imem_req, fif.imem_addr);
        end
        mem_en = 1'b1;
        n = 0;
        while (ack_log.size() < 4 && n < 20) begin step(); n++; end
        total++;
        if (ack_log.size() < 4) begin
            bad++;
            $display("FAIL redir_next_addr: got %0d acks want 4", ack_log.size());
        end else if (ack_log[2] !== 32'h8 || ack_log[3] !== 32'h100) begin
            bad++;
            $display("FAIL redir_next_addr: got %h %h want 8 100", ack_log[2], ack_log[3]);
        end
        n = 0;
        while (!fif.issue_valid && n < 20) begin step(); n++; end
        total++;
        if (fif.issue_valid !== 1'b1 || fif.instr_pc !== 32'h100) begin
            bad++;
            $display("FAIL redir_first_issue: got valid %b pc %h want 1 100", fif.issue_valid, fif.instr_pc);
        end
    endtask

    task automatic test_redirect_ack();
        int n;
        do_reset();
        ready_r = 1'b1; mem_en = 1'b1;
        n = 0;
        while (!(fif.imem_ack && ack_log.size() >= 2) && n < 30) begin step(); n++; end
        redir_r = 1'b1; redir_pc_r = 32'h200;
        sb.delete();
        step();
        redir_r = 1'b0;
        total++;
        if (fif.imem_req !== 1'b1 || fif.imem_addr !== 32'h200 || fif.issue_valid !== 1'b0) begin
            bad++;
            $display("FAIL redir_ack_req: got req %b addr %h valid %b want 1 200 0",
                     fif.imem_req, fif.imem_addr, fif.issue_valid);
        end
        n = 0;
        while (!fif.issue_valid && n < 20) begin step(); n++; end
        total++;
        if (fif.issue_valid !== 1'b1 || fif.instr_pc !== 32'h200) begin
            bad++;
            $display("FAIL redir_ack_issue: got valid %b pc %h want 1 200", fif.issue_valid, fif.instr_pc);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        mem_en = 1'b1;
        n = 0;
        while (ack_log.size() < 2 && n < 20) begin step(); n++; end
        mem_en = 1'b0;
        step();
        total++;
        if (fif.issue_valid !== 1'b1 || fif.imem_req !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_setup: got valid %b req %b want 1 1", fif.issue_valid, fif.imem_req);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (fif.imem_req !== 1'b0 || fif.issue_valid !== 1'b0 || fif.imem_addr !== RESET_PC) begin
            bad++;
            $display("FAIL rstmid_ctrl: got req %b valid %b addr %h want 0 0 %h",
                     fif.imem_req, fif.issue_valid, fif.imem_addr, RESET_PC);
        end
        total++;
        if (fif.instr !== 32'h0 || fif.op !== 6'h0 || fif.funct !== 6'h0 || fif.instr_pc !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_data: got instr %h pc %h want 0 0", fif.instr, fif.instr_pc);
        end
        step();
        sb.delete();
        ack_log.delete();
        stale_data = 32'hDEADBEEF; stale_ack = 1'b1;
        rst_n = 1'b1;
        step();
        stale_ack = 1'b0;
        total++;
        if (fif.issue_valid !== 1'b0 || fif.imem_req !== 1'b1 || fif.imem_addr !== RESET_PC) begin
            bad++;
            $display("FAIL rstmid_stale: got valid %b req %b addr %h want 0 1 %h",
                     fif.issue_valid, fif.imem_req, fif.imem_addr, RESET_PC);
        end
        ready_r = 1'b1; mem_en = 1'b1;
        n = 0;
        while (!fif.issue_valid && n < 20) begin step(); n++; end
        total++;
        if (fif.instr_pc !== RESET_PC || fif.instr !== 32'h012A4020) begin
            bad++;
            $display("FAIL rstmid_refetch: got pc %h word %h want %h 012a4020", fif.instr_pc, fif.instr, RESET_PC);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_full_pushpop();
        test_redirect();
        test_redirect_ack();
        test_reset_mid();
        ready_r = 1'b0; mem_en = 1'b0;
        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer end of the decoder interface: fetches 32-bit MIPS words from instruction memory and presents op and funct, plus the full word and its PC, to the downstream decode/control stage.
- Holds a small prefetch FIFO and a sequential PC.
- Accepts redirects from the branch/jump resolution path.
- Sits between the instruction memory port and the control/decode stage.

Parameters:
ADDR_W, 32, width of PC and memory address
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
RESET_PC, 0, first fetch address after reset (word aligned)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request valid
imem_addr  output  ADDR_W  fetch word address; low 2 bits always 0
imem_ack  input  1  memory returns imem_rdata this cycle for the outstanding request
imem_rdata  input  32  instruction word
redirect  input  1  one-cycle pulse: flush and restart fetch at redirect_pc
redirect_pc  input  ADDR_W  new fetch address; low 2 bits ignored and forced to 0
issue_ready  input  1  decode stage accepts the head entry
issue_valid  output  1  head entry valid
instr  output  32  head instruction word
op  output  6  instr[31:26]
funct  output  6  instr[5:0]
instr_pc  output  ADDR_W  address of the head instruction

Behaviour:
- Reset (async, rst_n low):
  - fetch_pc = RESET_PC; FIFO empty; no request outstanding; discard flag = 0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, issue_valid=0, instr/op/funct/instr_pc=0.
- Request rule:
  - At most one request outstanding.
  - imem_req is registered. It rises the cycle after (count + outstanding) < DEPTH becomes true with no request pending.
  - imem_req and imem_addr are held stable until the cycle imem_ack=1.
  - imem_req drops the cycle after the ack unless a new request is issued back-to-back. Back-to-back is permitted if space remains.
- Ack handling:
  - If the discard flag is clear: push {fetch_pc, imem_rdata} into the FIFO, then fetch_pc += 4, wrapping modulo 2^ADDR_W.
  - If the discard flag is set: drop the data, clear the flag, do not change fetch_pc.
  - The space check counts the outstanding request, so a push can never overflow the FIFO.
- Issue:
  - issue_valid = FIFO not empty.
  - instr/op/funct/instr_pc come combinationally from the head register and are forced to 0 when empty.
  - Pop when issue_valid && issue_ready && !redirect.
  - Push and pop in the same cycle are allowed at any occupancy, including full-with-pop and empty-with-push. A pushed entry becomes visible the next cycle; there is no fall-through.
- Redirect (highest priority):
  - FIFO is flushed and the pop is suppressed.
  - fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00}.
  - If a request is outstanding and imem_ack is not asserted this cycle, set the discard flag. The request stays asserted with its old address until acked, and that response is dropped.
  - If imem_ack is asserted in the same cycle as redirect, the data is dropped, the flag is not set, and the new request to redirect_pc may start next cycle.
  - If redirect repeats while discard is pending, only fetch_pc updates.
- Latency: with a 1-cycle-ack memory and an empty FIFO, the first issue_valid arrives 2 cycles after the request is accepted. Sustained throughput is one instruction per 2 cycles per outstanding slot.
- Reset mid-request: all state clears immediately. Any late ack after reset release is ignored because no request is outstanding.

Test Plan:
- Reset release, memory acks one cycle after each req, issue_ready=1 -> imem_addr sequence 0x0,0x4,0x8; issue_valid delivers op/funct of each word in order with instr_pc matching; 0x012A4020 gives op=0, funct=0x20.
- issue_ready=0 with DEPTH=4 -> exactly 4 acks accepted, then imem_req stays 0. Raise issue_ready -> 4 entries drain in order and fetching resumes at 0x10.
- Full FIFO with simultaneous pop and push -> no loss or duplication. Count stays at DEPTH and the order is preserved.
- Redirect to 0x103 while a request to 0x8 is outstanding, ack two cycles later -> the 0x8 word is never issued, the next imem_addr is 0x100, and the FIFO is empty the cycle after redirect.
- Redirect coincident with imem_ack -> ack data dropped, next request to redirect_pc, no discard of the following response.
- rst_n pulsed low mid-request with FIFO holding 2 entries -> outputs zero immediately. After release the first fetch address is RESET_PC, and a stale ack does not push.
